// File: rtl/linefollower_pwm.sv
// -----------------------------------------------------------------------------
// linefollower_pwm
//
// Line-following controller for an N-sensor reflectance array. Each cycle it
// classifies where the black line sits under the array, steers a five-state
// FSM (STRAIGHT, TURN_LEFT, TURN_RIGHT, SEARCH, STOP), and drives both wheels
// with PWM whose duty is derived from a runtime base speed. When the line is
// lost it pivots toward the last turn direction. If the line stays lost for
// LOST_CYCLES cycles it stops and raises `lost`.
//
// Build option:
//   SENSOR_SYNC_EN  defined   -> sensors pass a 2-flop synchronizer (reset to
//                                all ones) before classification; the
//                                sensor-to-state latency is 3 cycles.
//                   undefined -> sensors feed classification directly; the
//                                sensor-to-state latency is 1 cycle.
//
// Parameters:
//   NUM_SENSORS  sensor count, odd and >= 3; centre index C = (NUM_SENSORS-1)/2
//   PWM_W        PWM counter/duty width; PWM period = 2**PWM_W cycles
//   LOST_CYCLES  consecutive no-line cycles in SEARCH before STOP
//
// Ports:
//   clk         in   system clock, all logic on posedge
//   reset_n     in   asynchronous active-low reset
//   enable      in   1 = run; 0 = motors off at once, FSM forced to STOP
//   sensors     in   [NUM_SENSORS-1:0]; 1 = white, 0 = black; MSB = leftmost
//   speed_base  in   [PWM_W-1:0] base duty
//   motorLeft   out  left wheel PWM
//   motorRight  out  right wheel PWM
//   state       out  [2:0] FSM state: 0 STRAIGHT, 1 TURN_LEFT, 2 TURN_RIGHT,
//                    3 SEARCH, 4 STOP
//   lost        out  1 = STOP was reached through a SEARCH timeout
// -----------------------------------------------------------------------------
module linefollower_pwm #(
   parameter int NUM_SENSORS = 5,
   parameter int PWM_W       = 8,
   parameter int LOST_CYCLES = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   enable,
   input  logic [NUM_SENSORS-1:0] sensors,
   input  logic [PWM_W-1:0]       speed_base,
   output logic                   motorLeft,
   output logic                   motorRight,
   output logic [2:0]             state,
   output logic                   lost
);

   localparam int C    = (NUM_SENSORS - 1) / 2;
   localparam int LC_W = (LOST_CYCLES > 1) ? $clog2(LOST_CYCLES) : 1;

   typedef enum logic [2:0] {
      ST_STRAIGHT   = 3'd0,
      ST_TURN_LEFT  = 3'd1,
      ST_TURN_RIGHT = 3'd2,
      ST_SEARCH     = 3'd3,
      ST_STOP       = 3'd4
   } state_t;

   // last_dir encoding
   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   // --------------------------------------------------------------------------
   // Sensor path
   // --------------------------------------------------------------------------
   logic [NUM_SENSORS-1:0] s_cls;

`ifdef SENSOR_SYNC_EN
   logic [NUM_SENSORS-1:0] sync_1;
   logic [NUM_SENSORS-1:0] sync_2;

   // All ones on reset means "no line". For the first two cycles after reset
   // the FSM may therefore drift into SEARCH.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_1 <= '1;
         sync_2 <= '1;
      end else begin
         sync_1 <= sensors;
         sync_2 <= sync_1;
      end
   end

   assign s_cls = sync_2;
`else
   assign s_cls = sensors;
`endif

   // --------------------------------------------------------------------------
   // Classification
   // --------------------------------------------------------------------------
   logic flag_l;
   logic flag_r;
   logic all_blk;
   logic no_line;
   logic line_found;
   logic cls_left;
   logic cls_right;

   // A black sensor (0) anywhere left or right of centre raises that side.
   assign flag_l     = |(~s_cls[NUM_SENSORS-1:C+1]);
   assign flag_r     = |(~s_cls[C-1:0]);
   assign all_blk    = (s_cls == '0);
   assign no_line    = &s_cls;
   assign line_found = !all_blk && !no_line;
   assign cls_left   = flag_l && !flag_r;
   assign cls_right  = flag_r && !flag_l;

   // Tracking target for any "line found" pattern. Centre covers both the
   // middle-only case and L&R without all black.
   state_t track_target;

   always_comb begin
      track_target = ST_STRAIGHT;
      if (cls_left) begin
         track_target = ST_TURN_LEFT;
      end else if (cls_right) begin
         track_target = ST_TURN_RIGHT;
      end
   end

   // --------------------------------------------------------------------------
   // FSM
   // --------------------------------------------------------------------------
   state_t          state_q;
   state_t          state_d;
   logic            lost_q;
   logic            lost_d;
   logic            last_dir_q;
   logic            last_dir_d;
   logic [LC_W-1:0] miss_q;
   logic [LC_W-1:0] miss_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_STRAIGHT;
         lost_q     <= 1'b0;
         last_dir_q <= DIR_LEFT;
         miss_q     <= '0;
      end else begin
         state_q    <= state_d;
         lost_q     <= lost_d;
         last_dir_q <= last_dir_d;
         miss_q     <= miss_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      lost_d     = lost_q;
      last_dir_d = last_dir_q;
      miss_d     = miss_q;

      if (!enable) begin
         // Disable wins over everything. lost keeps its value.
         state_d = ST_STOP;
         miss_d  = '0;
      end else begin
         case (state_q)
            ST_STRAIGHT, ST_TURN_LEFT, ST_TURN_RIGHT: begin
               if (all_blk) begin
                  state_d = ST_STOP;
               end else if (no_line) begin
                  state_d = ST_SEARCH;
                  miss_d  = '0;
               end else begin
                  state_d = track_target;
               end
            end

            ST_SEARCH: begin
               // Priority order: all-black, then line found, then timeout.
               // This lets ALLBLK and line-found both win over a timeout
               // that lands in the same cycle.
               if (all_blk) begin
                  state_d = ST_STOP;
                  miss_d  = '0;
               end else if (line_found) begin
                  state_d = track_target;
                  miss_d  = '0;
               end else if (miss_q == LC_W'(LOST_CYCLES - 1)) begin
                  state_d = ST_STOP;
                  lost_d  = 1'b1;
                  miss_d  = '0;
               end else begin
                  miss_d = miss_q + 1'b1;
               end
            end

            ST_STOP: begin
               if (line_found) begin
                  state_d = ST_STRAIGHT;
                  lost_d  = 1'b0;
               end
            end

            default: begin
               state_d = ST_STOP;
            end
         endcase
      end

      // Remember the most recent turn so SEARCH can pivot toward it.
      if (state_d == ST_TURN_LEFT) begin
         last_dir_d = DIR_LEFT;
      end else if (state_d == ST_TURN_RIGHT) begin
         last_dir_d = DIR_RIGHT;
      end
   end

   assign state = state_q;
   assign lost  = lost_q;

   // --------------------------------------------------------------------------
   // PWM
   // --------------------------------------------------------------------------
   logic [PWM_W-1:0] cnt_q;
   logic [PWM_W-1:0] duty_l_q;
   logic [PWM_W-1:0] duty_r_q;
   logic [PWM_W-1:0] target_l;
   logic [PWM_W-1:0] target_r;
   logic [PWM_W-1:0] half_base;
   logic             wrap;

   assign half_base = speed_base >> 1;
   assign wrap      = &cnt_q;

   always_comb begin
      target_l = '0;
      target_r = '0;
      case (state_q)
         ST_STRAIGHT: begin
            target_l = speed_base;
            target_r = speed_base;
         end
         ST_TURN_LEFT: begin
            target_l = half_base;
            target_r = speed_base;
         end
         ST_TURN_RIGHT: begin
            target_l = speed_base;
            target_r = half_base;
         end
         ST_SEARCH: begin
            // Pivot: the inner wheel stops and the outer wheel runs at base.
            if (last_dir_q == DIR_LEFT) begin
               target_r = speed_base;
            end else begin
               target_l = speed_base;
            end
         end
         default: begin
            target_l = '0;
            target_r = '0;
         end
      endcase
   end

   // Duties load only on the wrap cycle, so each period runs start to finish
   // at one duty and a mid-period change never makes a short pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q    <= '0;
         duty_l_q <= '0;
         duty_r_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
         if (wrap) begin
            duty_l_q <= target_l;
            duty_r_q <= target_r;
         end
      end
   end

   // enable gates the outputs combinationally, so the motors drop in the
   // same cycle that enable falls.
   assign motorLeft  = enable && (cnt_q < duty_l_q);
   assign motorRight = enable && (cnt_q < duty_r_q);

endmodule

// File: tb/tb_linefollower_pwm.sv
// -----------------------------------------------------------------------------
// tb_linefollower_pwm
//
// Bench for linefollower_pwm (NUM_SENSORS=5, PWM_W=8, LOST_CYCLES=16, sync
// off). A reference model steps once per clock from the sampled inputs and
// pushes the expected {state, lost, left_on, right_on} into exp_q. The
// left_on/right_on bits tell whether each wheel would be high in this cycle
// if enabled. A monitor pops on the falling edge, applies the live enable
// gating and compares the result with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_linefollower_pwm;

   localparam int N     = 5;
   localparam int C     = 2;
   localparam int W     = 8;
   localparam int PER   = 256;
   localparam int LOST  = 16;

   // ---------------------------------------------------------------- clock/reset
   logic         clk = 1'b0;
   logic         reset_n;
   logic         enable;
   logic [N-1:0] sensors;
   logic [W-1:0] speed_base;
   logic         motorLeft;
   logic         motorRight;
   logic [2:0]   state;
   logic         lost;

   always #5 clk = ~clk;

   linefollower_pwm #(
      .NUM_SENSORS (N),
      .PWM_W       (W),
      .LOST_CYCLES (LOST)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .sensors    (sensors),
      .speed_base (speed_base),
      .motorLeft  (motorLeft),
      .motorRight (motorRight),
      .state      (state),
      .lost       (lost)
   );

   // ---------------------------------------------------------------- bookkeeping
   int checks = 0;
   int errors = 0;

   logic [5:0] exp_q[$];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // ---------------------------------------------------------------- reference model
   // Classes: 0 centre, 1 left, 2 right, 3 no line, 4 all black.
   // States use the same numbers as the DUT state output.
   int m_state     = 0;
   int m_lost      = 0;
   int m_dir_right = 0;
   int m_miss      = 0;
   int m_phase     = 0;
   int m_duty_l    = 0;
   int m_duty_r    = 0;

   function automatic int classify(input logic [N-1:0] s);
      int lb;
      int rb;
      int nb;
      lb = 0;
      rb = 0;
      nb = 0;
      for (int i = 0; i < N; i++) begin
         if (!s[i]) begin
            nb++;
            if (i > C) lb++;
            else if (i < C) rb++;
         end
      end
      if (nb == N) return 4;
      if (nb == 0) return 3;
      if (lb > 0 && rb == 0) return 1;
      if (rb > 0 && lb == 0) return 2;
      return 0;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      int cls;
      int b;
      if (!reset_n) begin
         m_state     = 0;
         m_lost      = 0;
         m_dir_right = 0;
         m_miss      = 0;
         m_phase     = 0;
         m_duty_l    = 0;
         m_duty_r    = 0;
         exp_q.delete();
      end else begin
         cls = classify(sensors);
         b   = int'(speed_base);

         // New period: pick up the duty for the state held during the last cycle.
         if (m_phase == PER - 1) begin
            case (m_state)
               0: begin m_duty_l = b;      m_duty_r = b;      end
               1: begin m_duty_l = b / 2;  m_duty_r = b;      end
               2: begin m_duty_l = b;      m_duty_r = b / 2;  end
               3: begin
                  m_duty_l = m_dir_right ? b : 0;
                  m_duty_r = m_dir_right ? 0 : b;
               end
               default: begin m_duty_l = 0; m_duty_r = 0; end
            endcase
         end
         m_phase = (m_phase + 1) % PER;

         if (!enable) begin
            m_state = 4;
            m_miss  = 0;
         end else begin
            case (m_state)
               0, 1, 2: begin
                  if (cls == 4) m_state = 4;
                  else if (cls == 3) begin m_state = 3; m_miss = 0; end
                  else m_state = cls;
               end
               3: begin
                  if (cls == 4) begin m_state = 4; m_miss = 0; end
                  else if (cls < 3) begin m_state = cls; m_miss = 0; end
                  else begin
                     m_miss++;
                     if (m_miss == LOST) begin
                        m_state = 4;
                        m_lost  = 1;
                        m_miss  = 0;
                     end
                  end
               end
               default: begin
                  if (cls < 3) begin m_state = 0; m_lost = 0; end
               end
            endcase
         end
         if (m_state == 1) m_dir_right = 0;
         else if (m_state == 2) m_dir_right = 1;

         exp_q.push_back({3'(m_state), m_lost != 0,
                          m_phase < m_duty_l, m_phase < m_duty_r});
      end
   end

   // ---------------------------------------------------------------- monitor
   always @(negedge clk) begin
      logic [5:0] e;
      if (!reset_n) begin
         check("reset_state", int'(state), 0);
         check("reset_lost", int'(lost), 0);
         check("reset_motor_left", int'(motorLeft), 0);
         check("reset_motor_right", int'(motorRight), 0);
      end else if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("state", int'(state), int'(e[5:3]));
         check("lost", int'(lost), int'(e[2]));
         check("motor_left", int'(motorLeft), int'(enable && e[1]));
         check("motor_right", int'(motorRight), int'(enable && e[0]));
      end
   end

   // ---------------------------------------------------------------- driver tasks
   task automatic step(input logic [N-1:0] s, input logic en, input logic [W-1:0] b,
                       input int n);
      sensors    = s;
      enable     = en;
      speed_base = b;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_phase(input int p);
      int k;
      k = 0;
      while (m_phase != p && k < 2 * PER) begin
         @(posedge clk);
         #1;
         k++;
      end
      if (k >= 2 * PER) begin
         errors++;
         $display("FAIL wait_phase: phase %0d not reached, expected %0d", m_phase, p);
      end
   endtask

   task automatic do_reset(input int n);
      reset_n = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
      reset_n = 1'b1;
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      int sel;
      int len;
      logic [N-1:0] rs;
      sensors    = 5'b11011;
      enable     = 1'b1;
      speed_base = 8'd128;
      reset_n    = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      reset_n = 1'b1;

      // Straight: motors stay low until the first wrap, then 128/256.
      step(5'b11011, 1'b1, 8'd128, 600);
      // Left then right turns.
      step(5'b01111, 1'b1, 8'd128, 300);
      step(5'b11110, 1'b1, 8'd128, 260);
      // Lose the line just before a wrap, so the pivot-right duty is loaded.
      wait_phase(248);
      step(5'b11111, 1'b1, 8'd128, 40);
      step(5'b11011, 1'b1, 8'd128, 300);
      // SEARCH then all black leads to STOP without lost.
      step(5'b11111, 1'b1, 8'd128, 5);
      step(5'b00000, 1'b1, 8'd128, 20);
      step(5'b11011, 1'b1, 8'd128, 300);
      // Enable drop mid-period.
      wait_phase(100);
      step(5'b11011, 1'b0, 8'd128, 5);
      step(5'b11011, 1'b1, 8'd128, 300);
      // Base speed change mid-period, then full and zero speed.
      wait_phase(10);
      step(5'b11011, 1'b1, 8'd255, 600);
      step(5'b11011, 1'b1, 8'd0, 300);
      // Reset in the middle of a period.
      step(5'b01111, 1'b1, 8'd200, 400);
      do_reset(3);
      step(5'b11011, 1'b1, 8'd90, 300);

      // Random segments.
      for (int i = 0; i < 250; i++) begin
         sel = $urandom_range(0, 9);
         len = $urandom_range(1, 30);
         if (sel < 2) rs = 5'b11111;
         else if (sel == 2) rs = 5'b00000;
         else rs = N'($urandom);
         step(rs, ($urandom_range(0, 9) != 0), W'($urandom), len);
      end

      repeat (2) @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // ---------------------------------------------------------------- watchdog
   initial begin
      #3_000_000;
      errors++;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
